flash_fetch_ctrl: RTL and testbench

- Instruction-fetch stage between the core control unit and the on-chip program flash.
- Turns the control unit's one-cycle `ld_flash` pulse plus the current PC into a flash word read.
- Returns the selected 16-bit Thumb halfword, with valid strobe, for the instruction register.
- Drives `flash_busy` back to the control unit, which stalls its state machine on it; holds a one-word line buffer so sequential halfwords skip the flash.

---
 rtl/cm0_fetch_pkg.sv | 29 ++
 rtl/fetch_line_buf.sv | 44 ++++
 rtl/flash_fetch_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_flash_fetch_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cm0_fetch_pkg.sv
// Shared definitions for the Cortex-M0 style instruction fetch stage:
// fetch FSM state encodings, the breakpoint opcode returned on a flash
// timeout, the default boot address and the halfword select helper.
package cm0_fetch_pkg;

  // Fetch FSM states; encodings are fixed and visible to checkers.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    DONE = 2'b11
  } fetch_state_t;

  // BKPT #0, handed to the core when the flash never answers.
  localparam logic [15:0] BKPT_OPCODE = 16'hBE00;

  // Byte address fetched automatically after reset.
  localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h0000_0000;

  // Cycles spent in WAIT before a fetch is abandoned.
  localparam int DEFAULT_TIMEOUT = 15;

  // Pick the Thumb halfword out of a 32-bit flash word (little endian).
  function automatic logic [15:0] select_half(input logic [31:0] word,
                                              input logic        upper);
    return upper ? word[31:16] : word[15:0];
  endfunction

endpackage

// File: rtl/fetch_line_buf.sv
// One-word line buffer for the fetch stage: remembers the last flash word
// read (tag + data + valid), reports a hit for a looked-up word address and
// returns the requested halfword of the buffered word. A timeout
// invalidates it so the next access to that word goes back to flash.
module fetch_line_buf
  import cm0_fetch_pkg::*;
#(
  parameter int TAG_W = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [TAG_W-1:0] load_tag,
  input  logic [31:0]      load_data,
  input  logic             invalidate,
  input  logic [TAG_W-1:0] lookup_tag,
  input  logic             lookup_upper,
  output logic             hit,
  output logic [15:0]      half
);

  logic             valid;
  logic [TAG_W-1:0] tag;
  logic [31:0]      data;

  // Buffer registers: invalidate has priority over a load in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (invalidate) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      tag   <= load_tag;
      data  <= load_data;
    end
  end

  assign hit  = valid && (tag == lookup_tag);
  assign half = select_half(data, lookup_upper);

endmodule

// File: rtl/flash_fetch_ctrl.sv
// Instruction fetch stage between the core control unit and program flash.
// A one-cycle ld_flash pulse plus pc_addr becomes a flash word read; the
// selected Thumb halfword is returned on instr with a one-cycle instr_valid.
// flash_busy stalls the control unit while a flash access is in progress.
// A request arriving while busy is parked in a single pending slot (latest
// address wins) and serviced straight from DONE without an IDLE gap.
// Build option FLASH_FETCH_LINEBUF_EN adds a one-word line buffer so that
// the other halfword of the last word read is served without the flash.
//
// Valid/ready contract on the flash side: fl_rd is raised with fl_addr
// stable and held until fl_ready is seen in WAIT; fl_rdata is taken only in
// that cycle, fl_ready in any other state is ignored, and fl_rd drops the
// cycle after (or immediately on rst).
module flash_fetch_ctrl
  import cm0_fetch_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(DEFAULT_RESET_ADDR),
  parameter int                TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_flash,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              flash_busy,
  output logic [15:0]       instr,
  output logic              instr_valid,
  output logic              fetch_err,
  output logic [ADDR_W-3:0] fl_addr,
  output logic              fl_rd,
  input  logic [31:0]       fl_rdata,
  input  logic              fl_ready
);

  localparam logic [3:0] LAST_WAIT = 4'(TIMEOUT - 1);

  // FSM state; kept under a plain name so checkers can bind to it.
  fetch_state_t      state;
  logic              booted;
  logic [ADDR_W-1:1] req_addr;   // halfword address of the fetch in progress
  logic              pend_valid;
  logic [ADDR_W-1:1] pend_addr;
  logic [3:0]        wait_cnt;

  logic              svc_req;
  logic [ADDR_W-1:1] svc_addr;
  logic              rd_done;
  logic              timeout_hit;
  logic              buf_hit;
  logic [15:0]       buf_half;

  // Byte-lane bit of the PC never matters for halfword fetches.
  logic unused_pc_bit0;
  assign unused_pc_bit0 = pc_addr[0];

  // Request to service this cycle: live pc in IDLE, pending/latest in DONE.
  always_comb begin
    svc_req  = 1'b0;
    svc_addr = pc_addr[ADDR_W-1:1];
    if (state == DONE) begin
      svc_req  = ld_flash || pend_valid;
      svc_addr = ld_flash ? pc_addr[ADDR_W-1:1] : pend_addr;
    end else if (state == IDLE) begin
      svc_req  = ld_flash && booted;
    end
  end

  // fl_ready beats the timeout when both land on the last WAIT cycle.
  assign rd_done     = (state == WAIT) && fl_ready;
  assign timeout_hit = (state == WAIT) && !fl_ready && (wait_cnt == LAST_WAIT);

`ifdef FLASH_FETCH_LINEBUF_EN
  fetch_line_buf #(
    .TAG_W(ADDR_W - 2)
  ) u_line_buf (
    .clk          (clk),
    .rst          (rst),
    .load         (rd_done),
    .load_tag     (req_addr[ADDR_W-1:2]),
    .load_data    (fl_rdata),
    .invalidate   (timeout_hit),
    .lookup_tag   (svc_addr[ADDR_W-1:2]),
    .lookup_upper (svc_addr[1]),
    .hit          (buf_hit),
    .half         (buf_half)
  );
`else
  assign buf_hit  = 1'b0;
  assign buf_half = 16'h0000;
`endif

  // Fetch FSM with registered outputs; rst drops any access at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      booted      <= 1'b0;
      req_addr    <= '0;
      pend_valid  <= 1'b0;
      pend_addr   <= '0;
      wait_cnt    <= '0;
      flash_busy  <= 1'b0;
      instr       <= 16'h0000;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      fl_addr     <= '0;
      fl_rd       <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!booted) begin
            // Boot fetch: no ld_flash needed, busy rises for the init logic.
            booted     <= 1'b1;
            req_addr   <= RESET_ADDR[ADDR_W-1:1];
            fl_addr    <= RESET_ADDR[ADDR_W-1:2];
            fl_rd      <= 1'b1;
            flash_busy <= 1'b1;
            state      <= REQ;
            if (ld_flash) begin
              pend_valid <= 1'b1;
              pend_addr  <= pc_addr[ADDR_W-1:1];
            end
          end else if (svc_req) begin
            req_addr <= svc_addr;
            if (buf_hit) begin
              instr       <= buf_half;
              instr_valid <= 1'b1;
            end else begin
              fl_addr    <= svc_addr[ADDR_W-1:2];
              fl_rd      <= 1'b1;
              flash_busy <= 1'b1;
              state      <= REQ;
            end
          end
        end
        REQ: begin
          wait_cnt <= '0;
          state    <= WAIT;
          if (ld_flash) begin
            pend_valid <= 1'b1;
            pend_addr  <= pc_addr[ADDR_W-1:1];
          end
        end
        WAIT: begin
          if (ld_flash) begin
            pend_valid <= 1'b1;
            pend_addr  <= pc_addr[ADDR_W-1:1];
          end
          if (rd_done || timeout_hit) begin
            state       <= DONE;
            fl_rd       <= 1'b0;
            instr_valid <= 1'b1;
            // Busy stays up through DONE when another fetch is queued.
            flash_busy  <= pend_valid || ld_flash;
            if (rd_done) begin
              instr <= select_half(fl_rdata, req_addr[1]);
            end else begin
              instr     <= BKPT_OPCODE;
              fetch_err <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        DONE: begin
          pend_valid <= 1'b0;
          if (svc_req) begin
            req_addr <= svc_addr;
            if (buf_hit) begin
              instr       <= buf_half;
              instr_valid <= 1'b1;
              flash_busy  <= 1'b0;
              state       <= IDLE;
            end else begin
              fl_addr    <= svc_addr[ADDR_W-1:2];
              fl_rd      <= 1'b1;
              flash_busy <= 1'b1;
              state      <= REQ;
            end
          end else begin
            flash_busy <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_fetch_ctrl.sv
// Bench for flash_fetch_ctrl. The bench plays both the control unit and the
// flash, so it knows ahead of time when fl_ready will arrive; each fetch is
// turned into a per-cycle expected waveform from the fetch rules and checked
// by one compare process on the falling edge. Literal checks pin key values.
module tb_flash_fetch_ctrl;

`ifdef FLASH_FETCH_LINEBUF_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld_flash = 1'b0;
  logic [31:0] pc_addr = '0;
  logic        flash_busy;
  logic [15:0] instr;
  logic        instr_valid;
  logic        fetch_err;
  logic [29:0] fl_addr;
  logic        fl_rd;
  logic [31:0] fl_rdata = '0;
  logic        fl_ready = 1'b0;

  flash_fetch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .ld_flash    (ld_flash),
    .pc_addr     (pc_addr),
    .flash_busy  (flash_busy),
    .instr       (instr),
    .instr_valid (instr_valid),
    .fetch_err   (fetch_err),
    .fl_addr     (fl_addr),
    .fl_rd       (fl_rd),
    .fl_rdata    (fl_rdata),
    .fl_ready    (fl_ready)
  );

  // Clock / reset block.
  always #5 clk = ~clk;

  typedef struct packed {
    logic        busy;
    logic        rd;
    logic [29:0] addr;
    logic        valid;
    logic [15:0] instr;
    logic        err;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] req;
  } lit_t;

  exp_t exp_q[$];
  lit_t lit_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model state.
  logic [15:0] m_instr;
  logic        m_err;
  logic        mb_valid;
  logic [29:0] mb_tag;
  logic [31:0] mb_data;
  logic [29:0] last_req;

  // Flash contents: two pinned words, the rest a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [29:0] wa);
    if (wa == 30'h0)  return 32'h4770_2001;
    if (wa == 30'h41) return 32'hE7FE_B500;
    return {wa[13:0], 2'b10, ~wa[15:0]} ^ 32'h5A5A_3C3C;
  endfunction

  function automatic exp_t mk(input logic busy, input logic rd,
                              input logic [29:0] addr, input logic valid);
    exp_t e;
    e.busy = busy; e.rd = rd; e.addr = addr; e.valid = valid;
    e.instr = m_instr; e.err = m_err;
    return e;
  endfunction

  function automatic logic spur();
    return ($urandom_range(0, 3) == 0);
  endfunction

  function automatic logic [31:0] pick_addr();
    if ($urandom_range(0, 9) == 0) return 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
    return 32'($urandom_range(0, 31));
  endfunction

  function automatic int pick_k();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return 16;
    if (r == 1) return 15;
    return $urandom_range(1, 4);
  endfunction

  task automatic lit(input string n, input logic [31:0] act, input logic [31:0] req);
    lit_q.push_back('{n, act, req});
  endtask

  // Driver: one cycle of inputs plus the outputs expected in that cycle.
  task automatic step(input logic ld, input logic [31:0] pc, input logic rdy,
                      input logic [31:0] rdata, input exp_t e);
    @(posedge clk);
    #1;
    ld_flash = ld;
    pc_addr  = pc;
    fl_ready = rdy;
    fl_rdata = rdata;
    exp_q.push_back(e);
  endtask

  // Expected behaviour from the cycle after a request is taken. k is the WAIT
  // cycle in which fl_ready arrives (16 = never). With chain, a second request
  // (a1, k1) is raised in the first WAIT cycle; dbl adds an earlier one in REQ
  // that the second must overwrite.
  task automatic serve(input logic [31:0] a0, input int k0, input bit chain,
                       input bit dbl, input logic [31:0] a1, input int k1);
    logic [31:0] a;
    logic [29:0] wa;
    logic [31:0] d;
    int          k;
    int          kk;
    bit          more;
    a = a0; k = k0; more = chain;
    while (1) begin
      wa = a[31:2];
      if (LB && mb_valid && (mb_tag == wa)) begin
        m_instr = a[1] ? mb_data[31:16] : mb_data[15:0];
        step(1'b0, $urandom, spur(), $urandom, mk(1'b0, 1'b0, '0, 1'b1));
        break;
      end
      step(more && dbl, $urandom, spur(), $urandom, mk(1'b1, 1'b1, wa, 1'b0));
      last_req = fl_addr;
      kk = (k > 15) ? 15 : k;
      for (int w = 1; w <= kk; w++) begin
        step(more && (w == 1), a1, (w == k), (w == k) ? mem_word(wa) : $urandom,
             mk(1'b1, 1'b1, wa, 1'b0));
      end
      if (k <= 15) begin
        d = mem_word(wa);
        mb_valid = 1'b1; mb_tag = wa; mb_data = d;
        m_instr = a[1] ? d[31:16] : d[15:0];
      end else begin
        m_err = 1'b1;
        mb_valid = 1'b0;
        m_instr = 16'hBE00;
      end
      step(1'b0, $urandom, spur(), $urandom, mk(more, 1'b0, '0, 1'b1));
      if (!more) break;
      a = a1; k = k1; more = 1'b0;
    end
  endtask

  task automatic issue(input logic [31:0] a, input int k, input bit chain,
                       input bit dbl, input logic [31:0] a1, input int k1);
    step(1'b1, a, spur(), $urandom, mk(1'b0, 1'b0, '0, 1'b0));
    serve(a, k, chain, dbl, a1, k1);
  endtask

  // Release reset mid-cycle; the boot fetch from address 0 follows.
  task automatic boot(input int k);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ld_flash = 1'b0;
    fl_ready = 1'b0;
    m_instr = 16'h0000; m_err = 1'b0; mb_valid = 1'b0;
    exp_q.push_back(mk(1'b0, 1'b0, '0, 1'b0));
    serve(32'h0, k, 1'b0, 1'b0, 32'h0, 0);
  endtask

  // Scoreboard: per-cycle waveform compare, then any literal checks.
  always @(negedge clk) begin
    exp_t e;
    lit_t l;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (flash_busy !== e.busy || fl_rd !== e.rd || instr_valid !== e.valid ||
          instr !== e.instr || fetch_err !== e.err || (e.rd && fl_addr !== e.addr)) begin
        failures++;
        $display("FAIL cycle t=%0t busy=%b/%b rd=%b/%b valid=%b/%b instr=%h/%h err=%b/%b fl_addr=%h/%h (actual/required)",
                 $time, flash_busy, e.busy, fl_rd, e.rd, instr_valid, e.valid,
                 instr, e.instr, fetch_err, e.err, fl_addr, e.addr);
      end
    end
    while (lit_q.size() > 0) begin
      l = lit_q.pop_front();
      checks++;
      if (l.act !== l.req) begin
        failures++;
        $display("FAIL %s actual=%h required=%h", l.name, l.act, l.req);
      end
    end
  end

  initial begin
    m_instr = '0; m_err = 1'b0; mb_valid = 1'b0; mb_tag = '0; mb_data = '0; last_req = '0;
    repeat (3) @(posedge clk);
    #1;
    lit("rst_busy", 32'(flash_busy), 32'h0);
    lit("rst_fl_rd", 32'(fl_rd), 32'h0);
    lit("rst_valid", 32'(instr_valid), 32'h0);
    lit("rst_instr", 32'(instr), 32'h0);
    lit("rst_err", 32'(fetch_err), 32'h0);

    // Boot with fl_ready two cycles after fl_rd.
    boot(2);
    lit("boot_fl_addr", 32'(last_req), 32'h0);
    lit("boot_instr", 32'(instr), 32'h2001);

    // Upper half of the boot word (buffer hit when enabled).
    issue(32'h2, 1, 1'b0, 1'b0, 32'h0, 0);
    lit("half_0x2", 32'(instr), 32'h4770);

    issue(32'h104, 3, 1'b0, 1'b0, 32'h0, 0);
    lit("fl_addr_0x104", 32'(last_req), 32'h41);
    lit("instr_0x104", 32'(instr), 32'hB500);
    issue(32'h106, 2, 1'b0, 1'b0, 32'h0, 0);
    lit("instr_0x106", 32'(instr), 32'hE7FE);

    // Timeout, then the same word must go back to flash.
    issue(32'h400, 16, 1'b0, 1'b0, 32'h0, 0);
    lit("timeout_err", 32'(fetch_err), 32'h1);
    lit("timeout_instr", 32'(instr), 32'hBE00);
    issue(32'h402, 1, 1'b0, 1'b0, 32'h0, 0);
    lit("after_timeout_miss", 32'(last_req), 32'h100);

    // fl_ready on the last WAIT cycle wins over the timeout.
    issue(32'h600, 15, 1'b0, 1'b0, 32'h0, 0);

    // Request queued during WAIT is issued straight from DONE.
    issue(32'h200, 2, 1'b1, 1'b0, 32'h300, 2);
    lit("chained_fl_addr", 32'(last_req), 32'hC0);

    // Reset in the middle of WAIT.
    step(1'b1, 32'h500, 1'b0, '0, mk(1'b0, 1'b0, '0, 1'b0));
    step(1'b0, 32'h0, 1'b0, '0, mk(1'b1, 1'b1, 30'h140, 1'b0));
    step(1'b0, 32'h0, 1'b0, '0, mk(1'b1, 1'b1, 30'h140, 1'b0));
    step(1'b0, 32'h0, 1'b0, '0, mk(1'b1, 1'b1, 30'h140, 1'b0));
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    lit("async_rst_fl_rd", 32'(fl_rd), 32'h0);
    lit("async_rst_busy", 32'(flash_busy), 32'h0);
    lit("async_rst_valid", 32'(instr_valid), 32'h0);
    repeat (2) @(posedge clk);
    boot(1);
    lit("reboot_fl_addr", 32'(last_req), 32'h0);

    // Randomized traffic with occasional queued, overwritten and timed-out fetches.
    for (int n = 0; n < 150; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++)
        step(1'b0, $urandom, spur(), $urandom, mk(1'b0, 1'b0, '0, 1'b0));
      issue(pick_addr(), pick_k(), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 1) == 1), pick_addr(), pick_k());
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
